// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants and types: opcodes, funct codes, instruction
// classes, plus the loader's state encoding.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [1:0] {
        KIND_RTYPE = 2'b00,
        KIND_LW    = 2'b01,
        KIND_SW    = 2'b10,
        KIND_BEQ   = 2'b11
    } instr_kind_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } load_state_e;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: instruction class plus raw fields -> 32-bit MIPS word.
// Fields that a class does not use are ignored.
module instr_field_packer
    import mips_isa_pkg::*;
(
    input  instr_kind_e kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    output logic [31:0] word
);

    always_comb begin
        word = '0;
        case (kind)
            KIND_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            KIND_LW:    word = {OP_LW, rs, rt, imm};
            KIND_SW:    word = {OP_SW, rs, rt, imm};
            KIND_BEQ:   word = {OP_BEQ, rs, rt, imm};
            default:    word = '0;
        endcase
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Accepts instruction descriptors over valid/ready, encodes them and writes
// them to consecutive instruction-memory words starting at a programmed base.
module instr_encode_loader
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [2:0]        fsm_state
);

    // Handshake: a descriptor transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on registered state, never on in_valid.
    load_state_e       state, state_next;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       packed_word;
    logic              accept;
    logic              start_ok;

    instr_field_packer u_packer (
        .kind  (instr_kind_e'(in_kind)),
        .rs    (in_rs),
        .rt    (in_rt),
        .rd    (in_rd),
        .shamt (in_shamt),
        .funct (in_funct),
        .imm   (in_imm),
        .word  (packed_word)
    );

    assign in_ready  = (state == ST_LOAD);
    assign accept    = in_valid && in_ready;
    assign start_ok  = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign busy      = (state == ST_LOAD) || (state == ST_FLUSH);
    assign done      = (state == ST_DONE);
    assign fsm_state = state;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start_ok) state_next = ST_LOAD;
            ST_LOAD: begin
                // A non-last word landing on the top address would wrap the
                // pointer into live code, so the session is abandoned instead.
                if (accept && in_last)     state_next = ST_FLUSH;
                else if (accept && (&ptr)) state_next = ST_ERR;
            end
            ST_FLUSH: state_next = ST_DONE;
            ST_DONE:  state_next = start_ok ? ST_LOAD : ST_IDLE;
            ST_ERR:   if (start_ok) state_next = ST_LOAD;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            count      <= '0;
            err        <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            state   <= state_next;
            imem_we <= accept;
            if (accept) begin
                imem_addr  <= ptr;
                imem_wdata <= packed_word;
                ptr        <= ptr + 1'b1;
            end
            if (start_ok) begin
                ptr   <= base_addr;
                count <= '0;
                err   <= 1'b0;
            end else begin
                if (imem_we)         count <= count + 1'b1;
                if (state == ST_ERR) err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader: fixed vector table, hand-written
// corner sequences and randomized sessions against a field-arithmetic model.
module tb_instr_encode_loader;

    localparam int ADDR_W = 8;

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
    } desc_t;

    typedef struct {
        desc_t       d;
        logic [7:0]  base;
        logic [31:0] word;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_kind;
    logic [4:0]        in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              busy, done, err;
    logic [2:0]        fsm_state;

    int         checks = 0;
    int         fails  = 0;
    int         cyc    = 0;
    logic [39:0] exp_q[$];
    int         wr_cyc[$];
    logic [7:0] m_ptr;
    vec_t       tbl[8];

    instr_encode_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_shamt   (in_shamt),
        .in_funct   (in_funct),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .fsm_state  (fsm_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every observed write must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required no write", imem_addr, imem_wdata);
            end else begin
                chk("imem_write", {24'h0, imem_addr, imem_wdata}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // Reference encoder built from field weights rather than bit concatenation.
    function automatic logic [31:0] ref_encode(input desc_t d);
        longint unsigned op, w;
        case (d.kind)
            2'd1:    op = 35;
            2'd2:    op = 43;
            2'd3:    op = 4;
            default: op = 0;
        endcase
        w = op * 64'd67108864 + longint'(d.rs) * 64'd2097152 + longint'(d.rt) * 64'd65536;
        if (d.kind == 2'd0)
            w = w + longint'(d.rd) * 64'd2048 + longint'(d.shamt) * 64'd64 + longint'(d.funct);
        else
            w = w + longint'(d.imm);
        return w[31:0];
    endfunction

    function automatic desc_t rand_desc();
        desc_t d;
        d.kind  = 2'($urandom_range(0, 3));
        d.rs    = 5'($urandom_range(0, 31));
        d.rt    = 5'($urandom_range(0, 31));
        d.rd    = 5'($urandom_range(0, 31));
        d.shamt = 5'($urandom_range(0, 31));
        d.funct = 6'($urandom_range(0, 63));
        d.imm   = 16'($urandom_range(0, 65535));
        return d;
    endfunction

    function automatic desc_t mk(input logic [1:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                                 input logic [15:0] imm);
        desc_t d;
        d.kind = k; d.rs = rs; d.rt = rt; d.rd = rd; d.shamt = sh; d.funct = fn; d.imm = imm;
        return d;
    endfunction

    // Driver tasks
    task automatic drive_desc(input desc_t d, input logic last);
        in_kind  = d.kind;
        in_rs    = d.rs;
        in_rt    = d.rt;
        in_rd    = d.rd;
        in_shamt = d.shamt;
        in_funct = d.funct;
        in_imm   = d.imm;
        in_last  = last;
    endtask

    task automatic send(input desc_t d, input logic last, input logic [7:0] addr, input logic [31:0] word);
        int n;
        drive_desc(d, last);
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: in_ready=%b, required 1 within 20 cycles", in_ready);
        end else begin
            exp_q.push_back({addr, word});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_model(input desc_t d, input logic last);
        send(d, last, m_ptr, ref_encode(d));
        m_ptr = m_ptr + 8'd1;
    endtask

    task automatic start_session(input logic [7:0] base);
        start     = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
        m_ptr = base;
    endtask

    // Called right after the last descriptor is accepted; leaves the bench in the DONE cycle.
    task automatic finish_session(input int exp_count);
        @(negedge clk);
        chk("flush_busy", busy, 1);
        chk("flush_done", done, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_count", count, exp_count);
        chk("done_busy", busy, 0);
        chk("done_err", err, 0);
        chk("pending_writes", exp_q.size(), 0);
    endtask

    task automatic no_accept(input int n);
        drive_desc(rand_desc(), 1'b0);
        in_valid = 1'b1;
        repeat (n) begin
            @(negedge clk);
            chk("blocked_ready", in_ready, 0);
            chk("blocked_done", done, 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_imem_we"}, imem_we, 0);
        chk({tag, "_imem_addr"}, imem_addr, 0);
        chk({tag, "_imem_wdata"}, imem_wdata, 0);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_state"}, fsm_state, 0);
    endtask

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        desc_t d;
        int sz, len, written;
        logic ovf, last, was_ff;
        logic [7:0] base;

        rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        drive_desc(mk(0, 0, 0, 0, 0, 0, 0), 1'b0);
        m_ptr = '0;

        tbl[0] = '{mk(2'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0000), 8'h00, 32'h00221820};
        tbl[1] = '{mk(2'd0, 5'd4, 5'd5, 5'd6, 5'd0, 6'h22, 16'h0000), 8'h7F, 32'h00853022};
        tbl[2] = '{mk(2'd0, 5'd0, 5'd3, 5'd2, 5'd4, 6'h00, 16'h0000), 8'h80, 32'h00031100};
        tbl[3] = '{mk(2'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0004), 8'h05, 32'h8D280004};
        tbl[4] = '{mk(2'd1, 5'd9, 5'd8, 5'd31, 5'd31, 6'h3F, 16'h0004), 8'h06, 32'h8D280004};
        tbl[5] = '{mk(2'd2, 5'd9, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0008), 8'hFF, 32'hAD280008};
        tbl[6] = '{mk(2'd3, 5'd1, 5'd2, 5'd17, 5'd9, 6'h15, 16'hFFFF), 8'hC3, 32'h1022FFFF};
        tbl[7] = '{mk(2'd0, 5'd31, 5'd31, 5'd31, 5'd31, 6'h2A, 16'hBEEF), 8'h3C, 32'h03FFFFEA};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_values("reset");
        rst = 1'b0;

        // Single R-type with exact done timing
        start_session(8'h10);
        send(tbl[0].d, 1'b1, 8'h10, 32'h00221820);
        @(negedge clk);
        chk("t1_flush_busy", busy, 1);
        chk("t1_flush_done", done, 0);
        chk("t1_flush_count", count, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_done", done, 1);
        chk("t1_count", count, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_done_cleared", done, 0);
        chk("t1_idle", fsm_state, 0);
        chk("t1_idle_ready", in_ready, 0);

        // Fixed vector table, one single-word session each
        for (int i = 0; i < 8; i++) begin
            start_session(tbl[i].base);
            send(tbl[i].d, 1'b1, tbl[i].base, tbl[i].word);
            finish_session(1);
        end

        // Back-to-back burst
        start_session(8'h40);
        send(tbl[3].d, 1'b0, 8'h40, 32'h8D280004);
        send(tbl[5].d, 1'b0, 8'h41, 32'hAD280008);
        send(mk(2'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'hFFFF), 1'b1, 8'h42, 32'h1022FFFF);
        finish_session(3);
        sz = wr_cyc.size();
        chk("burst_consecutive", wr_cyc[sz-1] - wr_cyc[sz-3], 2);

        // in_valid held in IDLE, then start and in_valid together
        @(posedge clk); #1;
        drive_desc(rand_desc(), 1'b0);
        in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_ready", in_ready, 0);
        end
        start = 1'b1;
        base_addr = 8'h50;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b0;
        m_ptr = 8'h50;
        @(negedge clk);
        chk("start_only_we", imem_we, 0);
        chk("start_only_count", count, 0);
        chk("start_only_ready", in_ready, 1);
        send_model(rand_desc(), 1'b0);
        start = 1'b1;
        base_addr = 8'hA0;
        @(posedge clk); #1;
        start = 1'b0;
        send_model(rand_desc(), 1'b1);
        finish_session(2);

        // Overflow at the top of the address space
        start_session(8'hFE);
        send_model(rand_desc(), 1'b0);
        send_model(rand_desc(), 1'b0);
        @(negedge clk);
        chk("ovf_ready_M", in_ready, 0);
        chk("ovf_err_M", err, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ovf_err", err, 1);
        chk("ovf_ready", in_ready, 0);
        chk("ovf_count", count, 2);
        chk("ovf_busy", busy, 0);
        no_accept(4);
        chk("ovf_err_sticky", err, 1);
        chk("ovf_no_third_write", exp_q.size(), 0);
        start_session(8'h20);
        @(negedge clk);
        chk("ovf_err_cleared", err, 0);
        chk("ovf_restart_busy", busy, 1);
        send_model(rand_desc(), 1'b1);
        finish_session(1);

        // Reset the cycle after an acceptance
        start_session(8'h30);
        send_model(rand_desc(), 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_values("midrst");
        chk("midrst_pending", exp_q.size(), 0);
        @(negedge clk);
        chk("midrst_no_we", imem_we, 0);
        start_session(8'h31);
        send_model(rand_desc(), 1'b1);
        finish_session(1);

        // Randomized sessions against the model
        for (int s = 0; s < 30; s++) begin
            base = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) base = 8'($urandom_range(250, 255));
            len = $urandom_range(1, 6);
            start_session(base);
            written = 0;
            ovf = 1'b0;
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                last = (i == len - 1);
                was_ff = (m_ptr == 8'hFF);
                send_model(rand_desc(), last);
                written++;
                if (!last && was_ff) begin
                    ovf = 1'b1;
                    break;
                end
            end
            if (ovf) begin
                @(negedge clk);
                chk("rnd_ovf_ready", in_ready, 0);
                @(posedge clk); #1;
                @(negedge clk);
                chk("rnd_ovf_err", err, 1);
                chk("rnd_ovf_count", count, written);
                no_accept(2);
                chk("rnd_ovf_pending", exp_q.size(), 0);
            end else begin
                finish_session(written);
            end
        end

        repeat (3) @(posedge clk);
        chk("final_pending", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/instr_encode_loader.md
# instr_encode_loader

Sequential instruction encoder and loader: the inverse of the opcode decoder in the single-cycle datapath. It accepts instruction descriptors over a valid/ready stream and packs each into a 32-bit MIPS word. The four supported classes are R-type, lw, sw and beq. It then writes the words into consecutive instruction-memory locations from a programmed base address. It sits between the testbench or boot host and the instruction memory, and fills program memory before the core runs.

## Interface
- ADDR_W, 8, instruction-memory word-address width; addresses wrap at 2^ADDR_W
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin load session at base_addr; honoured only in IDLE, DONE or ERR
- base_addr  in  ADDR_W  first word address, sampled on accepted start
- in_valid  in  1  descriptor valid
- in_ready  out  1  block can accept a descriptor this cycle
- in_kind  in  2  00 R-type, 01 lw, 10 sw, 11 beq
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields
- in_funct  in  6  R-type function field
- in_imm  in  16  immediate or branch offset
- in_last  in  1  final descriptor of the session
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written this session
- busy  out  1  state is LOAD or FLUSH
- done  out  1  one-cycle pulse at session end
- err  out  1  sticky address-overflow flag

## Operation
- States:
  - IDLE: reset state.
  - LOAD: accepting descriptors.
  - FLUSH: final write pending.
  - DONE: single cycle, then IDLE.
  - ERR: overflow.
- Transitions:
  - start in IDLE, DONE or ERR → LOAD. ptr ← base_addr, count ← 0, err ← 0.
  - In LOAD, accepting a descriptor with in_last=1 → FLUSH. FLUSH → DONE next cycle.
  - In LOAD, a write of a non-last word at ptr = all-ones → ERR. Ready drops starting the cycle after that write; ptr does not wrap into live code.
- Handshake:
  - A descriptor is accepted when in_valid && in_ready.
  - in_ready = 1 only in LOAD, and not in the cycle an overflow write occurs.
  - in_valid may be held without acceptance; descriptor fields are sampled only on acceptance.
- Encoding (unused fields ignored):
  - R-type: {6'b000000, rs, rt, rd, shamt, funct}
  - lw: {6'b100011, rs, rt, imm}
  - sw: {6'b101011, rs, rt, imm}
  - beq: {6'b000100, rs, rt, imm}
- Each accepted descriptor is written exactly once, at ptr. After the write, ptr increments modulo 2^ADDR_W and count increments.
- start while busy is ignored.
- start and in_valid in the same IDLE cycle: only start takes effect.
- rst at any time:
  - Returns to IDLE.
  - The pending write is dropped: imem_we is 0 from the next cycle.
  - Memory contents are left untouched.

## Timing
- Reset values:
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, count=0, busy=0, done=0, err=0.
- Latency:
  - A descriptor accepted in cycle N drives imem_we=1, imem_addr and imem_wdata in cycle N+1.
  - count updates in cycle N+2.
- Throughput:
  - One descriptor per cycle in LOAD. Back-to-back acceptance yields back-to-back writes.
- in_last accepted in cycle N:
  - write in N+1 (FLUSH)
  - done=1 in N+2 (DONE)
  - IDLE in N+3
- Overflow:
  - The all-ones write occurs in cycle M; err=1 and in_ready=0 from M+1.
  - done is never asserted for an overflowed session.
- Outputs are registered; there are no combinational paths from inputs to imem_*.

## Structure
- Shared package `mips_isa_pkg`:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ
  - instr_kind enum
  - funct constants (ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, SLT 6'h2A)
- Those same constants must also be used by the control unit.
- One natural combinational sub-module, `instr_field_packer` (kind + fields → 32-bit word), instantiated ahead of the write register.
- FSM, pointer and counter stay in the top module.

## Test plan
- start, base_addr=0x10; then R-type rs=1 rt=2 rd=3 shamt=0 funct=0x20, last=1 → single write at 0x10 with data 0x00221820; done pulses 2 cycles after acceptance; count=1.
- Back-to-back burst:
  - lw rs=9 rt=8 imm=4 → 0x8D280004 at addr A
  - sw rs=9 rt=8 imm=8 → 0xAD280008 at A+1
  - beq rs=1 rt=2 imm=0xFFFF, last → 0x1022FFFF at A+2
  - Requirements: three consecutive imem_we cycles; count=3.
- in_valid held with start not yet issued (IDLE) → in_ready=0, no writes. Start mid-session while busy → ignored; ptr unchanged.
- base_addr=0xFE, three non-last descriptors → writes at 0xFE and 0xFF, then err=1 and in_ready=0. The third descriptor is not written. A subsequent start clears err.
- rst asserted the cycle after acceptance → no imem_we that cycle onward; all outputs at reset values; next start works normally.
- Garbage in rd/shamt/funct for an lw descriptor → encoded word identical to the clean-field case.
